// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory controller.
//   state_t         : controller phase (BOOT = loading image, RUN = serving fetches)
//   IMEM_ADDR_W     : default byte-address width
//   IMEM_NOP_WORD   : word returned for a misaligned fetch (ADDI x0,x0,0)
//   is_word_aligned : true when the two low byte-address bits are zero
package imem_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int          IMEM_ADDR_W   = 20;
  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [1:0] byte_lsbs);
    return (byte_lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: arbitrates one single-port memory between
// the program loader and the IF stage, and sequences boot (IF held until the
// loader delivers the last image word).
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   ld_valid/ld_ready            loader write handshake
//   ld_addr/ld_data/ld_last      loader byte address, word, end-of-image flag
//   fe_req/fe_addr               IF fetch request and byte PC
//   fe_rdata/fe_valid            fetched word, 1-cycle valid pulse
//   fe_stall                     to hazard unit: hold PC / IF-ID
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata          memory port (sync read, 1-cycle latency)
//   boot_done                    high from the first RUN cycle onward
//   load_cnt                     loader words accepted, saturating
//   misalign_err                 pulse alongside fe_valid for a misaligned fetch
//   dbg_state                    current controller phase
//
// Handshake: a loader beat transfers in any cycle where ld_valid && ld_ready
// are both high at the rising edge; ld_valid/ld_addr/ld_data/ld_last must be
// stable while ld_valid is high and ld_ready is low. A fetch is accepted in
// every RUN cycle fe_req is high (the IF side has no ready; it is never
// refused in RUN) and is answered exactly one cycle later.
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int          ADDR_W      = IMEM_ADDR_W,
  parameter int          DATA_W      = 32,
  parameter bit          BOOT_BYPASS = 1'b0,
  parameter logic [31:0] NOP_WORD    = IMEM_NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              fe_req,
  input  logic [ADDR_W-1:0] fe_addr,
  output logic [DATA_W-1:0] fe_rdata,
  output logic              fe_valid,
  output logic              fe_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              boot_done,
  output logic [ADDR_W-3:0] load_cnt,
  output logic              misalign_err,
  output state_t            dbg_state
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));
  localparam state_t            RESET_ST   = BOOT_BYPASS ? ST_RUN : ST_BOOT;

  state_t              state_q, state_d;
  logic                rd_pend_q, rd_pend_d;     // aligned read in flight
  logic                mis_pend_q, mis_pend_d;   // misaligned fetch to answer
  logic [DATA_W-1:0]   hold_q, hold_d;           // last delivered fetch word
  logic [ADDR_W-3:0]   cnt_q, cnt_d;

  logic                ld_grant;
  logic                fe_rd_grant;
  logic                fe_mis_grant;
  logic                fe_aligned;

  assign fe_aligned = is_word_aligned(fe_addr[1:0]);

  // Phase FSM and grant decision.
  always_comb begin
    state_d      = state_q;
    ld_ready     = 1'b0;
    fe_stall     = 1'b0;
    ld_grant     = 1'b0;
    fe_rd_grant  = 1'b0;
    fe_mis_grant = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // IF is frozen; fe_req is ignored entirely.
        ld_ready = 1'b1;
        fe_stall = 1'b1;
        ld_grant = ld_valid;
        if (ld_valid && ld_last) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Fetch wins. A loader patch only goes through in a cycle with no
        // fetch, and the stall keeps the PC from advancing past it.
        ld_ready     = !fe_req;
        ld_grant     = ld_valid && !fe_req;
        fe_stall     = ld_grant;
        fe_rd_grant  = fe_req && fe_aligned;
        fe_mis_grant = fe_req && !fe_aligned;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Memory port: driven from whichever requester holds the grant, zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fe_rd_grant) begin
      mem_en   = 1'b1;
      mem_addr = fe_addr & ALIGN_MASK;
    end else if (ld_grant) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_addr & ALIGN_MASK;
      mem_wdata = ld_data;
    end
  end

  // Fetch response: memory data arrives combinationally one cycle after the
  // read strobe, so the response mux sits after the memory, not before it.
  always_comb begin
    fe_valid     = rd_pend_q || mis_pend_q;
    misalign_err = mis_pend_q;
    if (rd_pend_q)       fe_rdata = mem_rdata;
    else if (mis_pend_q) fe_rdata = NOP_WORD;
    else                 fe_rdata = hold_q;
  end

  always_comb begin
    rd_pend_d  = fe_rd_grant;
    mis_pend_d = fe_mis_grant;
    hold_d     = fe_valid ? fe_rdata : hold_q;
    cnt_d      = cnt_q;
    if (ld_grant && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_ST;
      rd_pend_q  <= 1'b0;
      mis_pend_q <= 1'b0;
      hold_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      mis_pend_q <= mis_pend_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
    end
  end

  assign boot_done = (state_q == ST_RUN);
  assign load_cnt  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_ctrl.sv
module tb_imem_ctrl;
  import imem_pkg::*;

  localparam int AW  = 20;
  localparam int BAW = 4;   // small address space: exercises counter saturation

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (BOOT_BYPASS=0) ----------------
  logic          ld_valid, ld_ready, ld_last;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          fe_req, fe_valid, fe_stall;
  logic [AW-1:0] fe_addr;
  logic [31:0]   fe_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          boot_done, misalign_err;
  logic [AW-3:0] load_cnt;
  state_t        dbg_state;

  imem_ctrl #(.ADDR_W(AW), .BOOT_BYPASS(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_rdata(fe_rdata),
    .fe_valid(fe_valid), .fe_stall(fe_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .boot_done(boot_done), .load_cnt(load_cnt),
    .misalign_err(misalign_err), .dbg_state(dbg_state)
  );

  logic [31:0] mem_a [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_a[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem_a[mem_addr[9:2]];
    end
  end

  // ---------------- bypass DUT (BOOT_BYPASS=1, ADDR_W=4) ----------------
  logic           b_ld_valid, b_ld_ready, b_ld_last;
  logic [BAW-1:0] b_ld_addr;
  logic [31:0]    b_ld_data;
  logic           b_fe_req, b_fe_valid, b_fe_stall;
  logic [BAW-1:0] b_fe_addr;
  logic [31:0]    b_fe_rdata;
  logic           b_mem_en, b_mem_we;
  logic [BAW-1:0] b_mem_addr;
  logic [31:0]    b_mem_wdata, b_mem_rdata;
  logic           b_boot_done, b_misalign_err;
  logic [BAW-3:0] b_load_cnt;
  state_t         b_dbg_state;

  imem_ctrl #(.ADDR_W(BAW), .BOOT_BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(b_ld_valid), .ld_ready(b_ld_ready), .ld_addr(b_ld_addr),
    .ld_data(b_ld_data), .ld_last(b_ld_last),
    .fe_req(b_fe_req), .fe_addr(b_fe_addr), .fe_rdata(b_fe_rdata),
    .fe_valid(b_fe_valid), .fe_stall(b_fe_stall),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .boot_done(b_boot_done), .load_cnt(b_load_cnt),
    .misalign_err(b_misalign_err), .dbg_state(b_dbg_state)
  );

  logic [31:0] mem_b [0:3];
  always @(posedge clk) begin
    if (b_mem_en) begin
      if (b_mem_we) mem_b[b_mem_addr[3:2]] <= b_mem_wdata;
      else          b_mem_rdata <= mem_b[b_mem_addr[3:2]];
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for the main fetch stream: every fe_valid must match the
  // oldest expected word; an unannounced fe_valid is an error.
  logic [31:0] exp_q[$];
  always @(negedge clk) begin
    if (rst_n && fe_valid) begin
      if (exp_q.size() == 0) chk("unexpected_fe_valid", 32'(fe_valid), 32'd0);
      else                   chk("fe_rdata", fe_rdata, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    fe_req = 1'b0; fe_addr = '0;
    b_ld_valid = 1'b0; b_ld_addr = '0; b_ld_data = '0; b_ld_last = 1'b0;
    b_fe_req = 1'b0; b_fe_addr = '0;
  endtask

  task automatic ld_beat(input logic [AW-1:0] a, input logic [31:0] d, input logic last);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    #1 rst_n = 1'b0;
    settle();
    // Reset state of both instances
    chk("rst_fe_valid",   32'(fe_valid), 32'd0);
    chk("rst_fe_rdata",   fe_rdata, 32'd0);
    chk("rst_load_cnt",   32'(load_cnt), 32'd0);
    chk("rst_boot_done",  32'(boot_done), 32'd0);
    chk("rst_state",      32'(dbg_state), 32'(ST_BOOT));
    chk("rst_fe_stall",   32'(fe_stall), 32'd1);
    chk("rst_misalign",   32'(misalign_err), 32'd0);
    chk("byp_boot_done",  32'(b_boot_done), 32'd1);
    chk("byp_fe_stall",   32'(b_fe_stall), 32'd0);
    chk("byp_state",      32'(b_dbg_state), 32'(ST_RUN));
    #10 rst_n = 1'b1;

    // BOOT: fetch requests ignored while loading
    step(); fe_req = 1'b1; fe_addr = '0; settle();
    chk("boot_fe_no_mem", 32'(mem_en), 32'd0);
    chk("boot_ld_ready",  32'(ld_ready), 32'd1);

    step(); ld_beat(20'h0, 32'h11, 1'b0); settle();
    chk("beat1_we",    32'(mem_we), 32'd1);
    chk("beat1_addr",  32'(mem_addr), 32'h0);
    chk("beat1_wdata", mem_wdata, 32'h11);
    step(); ld_beat(20'h5, 32'h22, 1'b0); settle();   // low bits dropped
    chk("beat2_addr",  32'(mem_addr), 32'h4);
    step(); ld_beat(20'h8, 32'h33, 1'b1); settle();
    chk("beat3_boot_done", 32'(boot_done), 32'd0);
    chk("beat3_fe_stall",  32'(fe_stall), 32'd1);
    step(); ld_valid = 1'b0; ld_last = 1'b0; fe_req = 1'b0; settle();
    chk("run_boot_done",  32'(boot_done), 32'd1);
    chk("run_fe_stall",   32'(fe_stall), 32'd0);
    chk("run_load_cnt",   32'(load_cnt), 32'd3);
    chk("run_idle_mem",   32'(mem_en), 32'd0);
    chk("run_idle_addr",  32'(mem_addr), 32'd0);

    // RUN: back-to-back fetches 0,4,8
    step(); fe_req = 1'b1; fe_addr = 20'h0; exp_q.push_back(32'h11); settle();
    chk("fetch_mem_en",   32'(mem_en), 32'd1);
    chk("fetch_mem_we",   32'(mem_we), 32'd0);
    chk("fetch_ld_ready", 32'(ld_ready), 32'd0);
    step(); fe_addr = 20'h4; exp_q.push_back(32'h22); settle();
    chk("b2b_valid1", 32'(fe_valid), 32'd1);
    step(); fe_addr = 20'h8; exp_q.push_back(32'h33); settle();
    chk("b2b_valid2", 32'(fe_valid), 32'd1);
    step(); fe_req = 1'b0; settle();
    chk("b2b_valid3", 32'(fe_valid), 32'd1);
    step();
    chk("hold_valid", 32'(fe_valid), 32'd0);
    chk("hold_rdata", fe_rdata, 32'h33);

    // RUN: fetch and loader collide; fetch wins, patch goes next cycle
    fe_req = 1'b1; fe_addr = 20'h8; exp_q.push_back(32'h33);
    ld_beat(20'h4, 32'hAB, 1'b1); settle();
    chk("coll_ld_ready", 32'(ld_ready), 32'd0);
    chk("coll_mem_we",   32'(mem_we), 32'd0);
    chk("coll_mem_addr", 32'(mem_addr), 32'h8);
    chk("coll_fe_stall", 32'(fe_stall), 32'd0);
    step(); fe_req = 1'b0; settle();
    chk("patch_ld_ready", 32'(ld_ready), 32'd1);
    chk("patch_mem_we",   32'(mem_we), 32'd1);
    chk("patch_mem_addr", 32'(mem_addr), 32'h4);
    chk("patch_wdata",    mem_wdata, 32'hAB);
    chk("patch_stall",    32'(fe_stall), 32'd1);
    step(); ld_valid = 1'b0; ld_last = 1'b0;
    fe_req = 1'b1; fe_addr = 20'h4; exp_q.push_back(32'hAB); settle();
    chk("patch_state", 32'(dbg_state), 32'(ST_RUN));
    step(); fe_req = 1'b0; settle();
    chk("patch_cnt", 32'(load_cnt), 32'd4);

    // RUN: misaligned fetch
    step(); fe_req = 1'b1; fe_addr = 20'h6; exp_q.push_back(32'h13); settle();
    chk("mis_no_mem", 32'(mem_en), 32'd0);
    step(); fe_req = 1'b0; settle();
    chk("mis_err",   32'(misalign_err), 32'd1);
    chk("mis_valid", 32'(fe_valid), 32'd1);
    chk("mis_rdata", fe_rdata, 32'h13);
    step();
    chk("mis_err_clr", 32'(misalign_err), 32'd0);
    chk("mis_hold",    fe_rdata, 32'h13);

    // Reset in the middle of a fetch
    fe_req = 1'b1; fe_addr = 20'h0;
    step(); fe_req = 1'b0;
    rst_n = 1'b0; settle();
    chk("midrst_fe_valid",  32'(fe_valid), 32'd0);
    chk("midrst_state",     32'(dbg_state), 32'(ST_BOOT));
    chk("midrst_boot_done", 32'(boot_done), 32'd0);
    chk("midrst_load_cnt",  32'(load_cnt), 32'd0);
    chk("midrst_fe_rdata",  fe_rdata, 32'd0);
    #3 rst_n = 1'b1;
    // Reload only a word away from 0, then confirm word 0 survived reset
    step(); ld_beat(20'h40, 32'h77, 1'b1);
    step(); ld_valid = 1'b0; ld_last = 1'b0; settle();
    chk("reload_cnt",  32'(load_cnt), 32'd1);
    chk("reload_done", 32'(boot_done), 32'd1);
    step(); fe_req = 1'b1; fe_addr = 20'h0; exp_q.push_back(32'h11);
    step(); fe_req = 1'b0;

    // Bypass instance: patches in RUN, counter saturation, ld_last inert
    for (int i = 0; i < 4; i++) begin
      step();
      b_ld_valid = 1'b1; b_ld_last = 1'b1;
      b_ld_addr = BAW'(i * 4); b_ld_data = 32'hA0 + 32'(i);
      settle();
      if (i == 3) chk("byp_cnt_3", 32'(b_load_cnt), 32'd3);
      if (i == 0) chk("byp_patch_stall", 32'(b_fe_stall), 32'd1);
    end
    step(); b_ld_valid = 1'b0; b_ld_last = 1'b0; settle();
    chk("byp_cnt_sat",  32'(b_load_cnt), 32'd3);
    chk("byp_still_run", 32'(b_dbg_state), 32'(ST_RUN));
    step(); b_fe_req = 1'b1; b_fe_addr = 4'h8;
    step(); b_fe_req = 1'b0; settle();
    chk("byp_fe_valid", 32'(b_fe_valid), 32'd1);
    chk("byp_fe_rdata", b_fe_rdata, 32'hA2);

    step(); step();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
